// File: rtl/tx_ilas_seq_if.sv
// Bundle of the sequencer's SYNC~, config, user-data and link-side octet signals.
// master is the sequencer's own view; slave is the environment driving it.
interface tx_ilas_seq_if;
  logic         i_sync_n;
  logic [103:0] i_cfg;
  logic [7:0]   i_data;
  logic         i_vld;
  logic         o_ready;
  logic [7:0]   o_data;
  logic         o_k;
  logic         o_vld;
  logic         o_lmfc;
  logic         o_underflow;

  modport master (
    input  i_sync_n, i_cfg, i_data, i_vld,
    output o_ready, o_data, o_k, o_vld, o_lmfc, o_underflow
  );

  modport slave (
    output i_sync_n, i_cfg, i_data, i_vld,
    input  o_ready, o_data, o_k, o_vld, o_lmfc, o_underflow
  );
endinterface

// File: rtl/tx_ilas_seq.sv
// JESD204B transmit sequencer: code-group sync, 4-multiframe ILAS, then user data,
// with all octet outputs registered one cycle behind the state that produced them.
module tx_ilas_seq #(
  parameter int unsigned F          = 1,
  parameter int unsigned K          = 32,
  parameter int unsigned RESYNC_CYC = 5
) (
  input logic           clk,
  input logic           rst,
  tx_ilas_seq_if.master bus
);
  localparam int unsigned     FK      = F * K;
  localparam int unsigned     CntW    = $clog2(RESYNC_CYC + 1);
  localparam logic [7:0]      PLast   = 8'(FK - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(RESYNC_CYC - 1);

  if (FK < 18 || FK > 256) begin : g_bad_fk
    $error("tx_ilas_seq: F*K must lie in 18..256");
  end
  if (RESYNC_CYC < 1) begin : g_bad_resync
    $error("tx_ilas_seq: RESYNC_CYC must be at least 1");
  end

  typedef enum logic [1:0] {StCgs, StIlas, StData} state_e;

  state_e          state_q, state_d;
  logic [7:0]      p_q, p_d;
  logic [1:0]      m_q, m_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [103:0]    cfg_q, cfg_d;
  logic [7:0]      data_q, data_d;
  logic            k_q, k_d;
  logic            vld_q;
  logic            lmfc_q;
  logic            uf_q, uf_d;
  logic [7:0]      fchk;
  logic [7:0]      cfg_oct;
  logic            p_last;

  assign p_last = (p_q == PLast);

  // Checksum and config-octet lookup work on the copy latched at ILAS entry.
  always_comb begin
    fchk    = '0;
    cfg_oct = '0;
    for (int i = 0; i < 13; i++) begin
      fchk = fchk + cfg_q[8*i +: 8];
      if (p_q == 8'(i + 2)) cfg_oct = cfg_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_last ? 8'd0 : p_q + 8'd1;
    m_d     = m_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    data_d  = 8'hBC;
    k_d     = 1'b1;
    uf_d    = 1'b0;

    unique case (state_q)
      StCgs: begin
        cnt_d = '0;
        if (p_last && bus.i_sync_n) begin
          state_d = StIlas;
          m_d     = 2'd0;
          cfg_d   = bus.i_cfg;
        end
      end
      StIlas: begin
        data_d = p_q;
        k_d    = 1'b0;
        if (p_q == 8'd0) begin
          data_d = 8'h1C;
          k_d    = 1'b1;
        end else if (p_last) begin
          data_d = 8'h7C;
          k_d    = 1'b1;
        end
        if (m_q == 2'd1) begin
          if (p_q == 8'd1) begin
            data_d = 8'h9C;
            k_d    = 1'b1;
          end else if (p_q >= 8'd2 && p_q <= 8'd14) begin
            data_d = cfg_oct;
          end else if (p_q == 8'd15) begin
            data_d = fchk;
          end
        end
        if (p_last) begin
          m_d = m_q + 2'd1;
          if (m_q == 2'd3) state_d = StData;
        end
      end
      StData: begin
        k_d    = 1'b0;
        data_d = bus.i_vld ? bus.i_data : 8'h00;
        uf_d   = ~bus.i_vld;
      end
      default: state_d = StCgs;
    endcase

    // Only a run of RESYNC_CYC lows is a resync; it overrides ILAS->DATA.
    if (state_q != StCgs) begin
      if (bus.i_sync_n) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        state_d = StCgs;
        m_d     = 2'd0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StCgs;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      cfg_q   <= '0;
      data_q  <= '0;
      k_q     <= 1'b0;
      vld_q   <= 1'b0;
      lmfc_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      data_q  <= data_d;
      k_q     <= k_d;
      vld_q   <= 1'b1;
      lmfc_q  <= (p_q == 8'd0);
      uf_q    <= uf_d;
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_k         = k_q;
  assign bus.o_vld       = vld_q;
  assign bus.o_lmfc      = lmfc_q;
  assign bus.o_underflow = uf_q;
  assign bus.o_ready     = (state_q == StData);

endmodule

// File: doc/tx_ilas_seq.md
TX_ILAS_SEQ -- requirements
Module: tx_ilas_seq

Interface
REQ-001 SHALL have parameter F, default 1, octets per frame.
REQ-002 SHALL have parameter K, default 32, frames per multiframe; F*K SHALL be in the range 18..256 (elaboration error otherwise).
REQ-003 SHALL have parameter RESYNC_CYC, default 5, consecutive low i_sync_n cycles that form a resync request.
REQ-004 SHALL have port clk  input  1  character clock, one octet per cycle.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port i_sync_n  input  1  receiver SYNC~ (active low), already synchronous to clk.
REQ-007 SHALL have port i_cfg  input  104  ILAS config octets 0..12; octet n is i_cfg[8n+7:8n].
REQ-008 SHALL have port i_data  input  8  user octet.
REQ-009 SHALL have port i_vld  input  1  i_data valid.
REQ-010 SHALL have port o_ready  output  1  i_data is consumed this cycle.
REQ-011 SHALL have port o_data  output  8  octet to tx_link_layer i_data.
REQ-012 SHALL have port o_k  output  1  o_data is a control character.
REQ-013 SHALL have port o_vld  output  1  o_data valid.
REQ-014 SHALL have port o_lmfc  output  1  pulse; the emitted octet is LMFC position 0.
REQ-015 SHALL have port o_underflow  output  1  pulse; DATA octet emitted while i_vld=0.

Function
REQ-016 SHALL keep a free-running LMFC counter p, 0..F*K-1, which wraps to 0 after F*K-1 and runs in every state.
REQ-017 SHALL implement the states CGS, ILAS and DATA, with a 2-bit multiframe index m used in ILAS.
REQ-018 SHALL register all outputs: the octet emitted at cycle t is a function of the state, p, m and the inputs at cycle t-1 (1-cycle latency).
REQ-019 In CGS, SHALL emit K28.5: o_data=0xBC, o_k=1, o_vld=1.
REQ-020 SHALL go CGS->ILAS with m=0 once i_sync_n=1 was sampled and p==F*K-1, so that ILAS octet 0 coincides with p=0.
  - If i_sync_n is still low at p==F*K-1, SHALL stay in CGS.
REQ-021 In ILAS, SHALL emit per position p:
  - p=0: K28.0 (0x1C, k=1).
  - p=F*K-1: K28.3 (0x7C, k=1).
  - Otherwise: data octet p[7:0], k=0.
REQ-022 In ILAS with m=1, SHALL override the ILAS octets as follows:
  - p=1: K28.4 (0x9C, k=1).
  - p=2..14: i_cfg octet p-2, k=0.
  - p=15: FCHK = (sum of i_cfg octets 0..12) mod 256, k=0.
REQ-023 SHALL sample i_cfg once at ILAS entry and hold it for the rest of that ILAS sequence.
REQ-024 SHALL increment m at each p wrap in ILAS, and after the octet with m=3, p=F*K-1 SHALL enter DATA.
REQ-025 In DATA, SHALL drive o_ready=1 and emit o_data=i_data, o_k=0, o_vld=1.
  - If i_vld=0: SHALL emit 0x00 with o_k=0 and pulse o_underflow.
REQ-026 o_ready SHALL be 0 in CGS and ILAS, and i_data/i_vld SHALL be ignored there.
REQ-027 SHALL count consecutive low i_sync_n cycles in ILAS and DATA, and on reaching RESYNC_CYC SHALL enter CGS.
  - The first K28.5 SHALL appear on the next output cycle.
  - Shorter low pulses (error reports) SHALL be ignored and SHALL clear the count.
REQ-028 The resync request SHALL take priority over the ILAS->DATA transition when both occur in the same cycle.
REQ-029 o_lmfc SHALL be 1 exactly when the emitted octet corresponds to p=0, in every state except reset.

Reset
REQ-030 While rst=1, SHALL hold o_data=0x00, o_k=0, o_vld=0, o_ready=0, o_lmfc=0, o_underflow=0, p=0, m=0, state=CGS, resync count=0.
REQ-031 SHALL apply reset asynchronously at any time, including mid-ILAS and mid-DATA.
REQ-032 After rst deasserts, the first output cycle SHALL be K28.5 with o_vld=1 and o_lmfc=1.

Verification
REQ-033 Reset then i_sync_n=0 for 100 cycles (F=1, K=32) -> every octet 0xBC/k=1; o_lmfc pulses every 32 cycles.
REQ-034 Release i_sync_n at p=10 -> CGS continues until the next p=0; then ILAS: 0x1C at p=0, 0x7C at p=31, ramp 0x01..0x1E between.
REQ-035 i_cfg octets = 0x01..0x0D -> ILAS multiframe 1 shows 0x9C at p=1, 0x01..0x0D at p=2..14, FCHK 0x5B at p=15.
REQ-036 After 4 ILAS multiframes, drive i_vld=1 with an incrementing i_data -> o_data follows one cycle later, o_k=0; drop i_vld one cycle -> 0x00 emitted and o_underflow pulses once.
REQ-037 In DATA, i_sync_n low for 2 cycles -> no state change; low for 5 cycles -> K28.5 from the next output cycle.
REQ-038 Assert rst during ILAS multiframe 2 -> outputs zero immediately; after release the sequence restarts at CGS with p=0.
